// File: rtl/bus_sequencer.sv
// CPU bus front-end for the three-counter timer: syncs CS/RD/WR, decodes writes into strobes, muxes read data.
// Latency: write strobes SYNC_STAGES+1 edges after WR rises; D_out/D_oe SYNC_STAGES+1 edges after RD falls.
// Backpressure: none; the host bus is paced only by its own strobe widths, overlapping RD/WR aborts the access.
//
// Ports: CLK/RESET (sync, active-high); CS/RD/WR active-low async strobes; A/D_in address and write data;
// D_out/D_oe registered read data and enable; control_word/cw_strobe, D_wr/wr_strobe/wr_msb, latch_strobe
// are one-cycle commands to the counters; count0..2 and status0..2 are the counters' readable values.
module bus_sequencer #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        CS,
    input  logic        RD,
    input  logic        WR,
    input  logic [1:0]  A,
    input  logic [7:0]  D_in,
    output logic [7:0]  D_out,
    output logic        D_oe,
    output logic [7:0]  control_word,
    output logic [2:0]  cw_strobe,
    output logic [2:0]  wr_strobe,
    output logic [7:0]  D_wr,
    output logic        wr_msb,
    output logic [2:0]  latch_strobe,
    input  logic [15:0] count0,
    input  logic [15:0] count1,
    input  logic [15:0] count2,
    input  logic [7:0]  status0,
    input  logic [7:0]  status1,
    input  logic [7:0]  status2
);

    typedef enum logic [1:0] {IDLE, WR_ACT, RD_ACT, ABORT} state_t;

    // synchronizers, idle (high) after reset
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] rd_sync_q, rd_sync_d;
    logic [SYNC_STAGES-1:0] wr_sync_q, wr_sync_d;
    logic cs_s, rd_s, wr_s;

    state_t      state_q, state_d;
    logic [1:0]  waddr_q, waddr_d;
    logic [7:0]  wdat_q, wdat_d;
    logic [1:0]  rd_a_q, rd_a_d;
    logic        rd_status_q, rd_status_d;   // current read returned a status byte

    logic [2:0][1:0] rw_mode_q, rw_mode_d;
    logic [2:0]      wptr_q, wptr_d;
    logic [2:0]      rptr_q, rptr_d;
    logic [2:0]      status_pending_q, status_pending_d;

    logic [7:0]  d_out_q, d_out_d;
    logic        d_oe_q, d_oe_d;
    logic [7:0]  control_word_q, control_word_d;
    logic [2:0]  cw_strobe_q, cw_strobe_d;
    logic [2:0]  wr_strobe_q, wr_strobe_d;
    logic [7:0]  d_wr_q, d_wr_d;
    logic        wr_msb_q, wr_msb_d;
    logic [2:0]  latch_strobe_q, latch_strobe_d;

    logic [2:0][15:0] count_all;
    logic [2:0][7:0]  status_all;

    assign count_all  = {count2, count1, count0};
    assign status_all = {status2, status1, status0};

    assign cs_s = cs_sync_q[SYNC_STAGES-1];
    assign rd_s = rd_sync_q[SYNC_STAGES-1];
    assign wr_s = wr_sync_q[SYNC_STAGES-1];

    always_comb begin
        cs_sync_d = {cs_sync_q[SYNC_STAGES-2:0], CS};
        rd_sync_d = {rd_sync_q[SYNC_STAGES-2:0], RD};
        wr_sync_d = {wr_sync_q[SYNC_STAGES-2:0], WR};
    end

    always_comb begin
        state_d          = state_q;
        waddr_d          = waddr_q;
        wdat_d           = wdat_q;
        rd_a_d           = rd_a_q;
        rd_status_d      = rd_status_q;
        rw_mode_d        = rw_mode_q;
        wptr_d           = wptr_q;
        rptr_d           = rptr_q;
        status_pending_d = status_pending_q;
        d_out_d          = d_out_q;
        d_oe_d           = 1'b0;
        control_word_d   = control_word_q;
        cw_strobe_d      = 3'b000;
        wr_strobe_d      = 3'b000;
        d_wr_d           = d_wr_q;
        wr_msb_d         = wr_msb_q;
        latch_strobe_d   = 3'b000;

        case (state_q)
            IDLE: begin
                if (!cs_s) begin
                    if (!rd_s && !wr_s) begin
                        state_d = ABORT;
                    end else if (!wr_s) begin
                        state_d = WR_ACT;
                        waddr_d = A;
                        wdat_d  = D_in;
                    end else if (!rd_s) begin
                        state_d     = RD_ACT;
                        rd_a_d      = A;
                        rd_status_d = 1'b0;
                        d_oe_d      = (A != 2'd3);
                        // A=11 matches no counter, so D_out keeps its old value
                        for (int i = 0; i < 3; i++) begin
                            if (A == 2'(i)) begin
                                if (status_pending_q[i]) begin
                                    d_out_d     = status_all[i];
                                    rd_status_d = 1'b1;
                                end else begin
                                    case (rw_mode_q[i])
                                        2'b10:   d_out_d = count_all[i][15:8];
                                        2'b11:   d_out_d = rptr_q[i] ? count_all[i][15:8]
                                                                     : count_all[i][7:0];
                                        default: d_out_d = count_all[i][7:0];
                                    endcase
                                end
                            end
                        end
                    end
                end
            end

            WR_ACT: begin
                waddr_d = A;
                wdat_d  = D_in;
                if (cs_s || (!rd_s && !wr_s)) begin
                    state_d = ABORT;
                end else if (wr_s) begin
                    // commit uses the byte registered while WR was still low
                    state_d = IDLE;
                    if (waddr_q == 2'd3) begin
                        if (wdat_q[7:6] == 2'b11) begin
                            // read-back: bit i+1 selects counter i, bit5/bit4 are active-low
                            for (int i = 0; i < 3; i++) begin
                                if (wdat_q[i+1]) begin
                                    if (!wdat_q[5]) latch_strobe_d[i] = 1'b1;
                                    if (!wdat_q[4]) status_pending_d[i] = 1'b1;
                                end
                            end
                        end else if (wdat_q[5:4] == 2'b00) begin
                            for (int i = 0; i < 3; i++) begin
                                if (wdat_q[7:6] == 2'(i)) begin
                                    latch_strobe_d[i] = 1'b1;
                                    rptr_d[i]         = 1'b0;
                                end
                            end
                        end else begin
                            control_word_d = wdat_q;
                            for (int i = 0; i < 3; i++) begin
                                if (wdat_q[7:6] == 2'(i)) begin
                                    rw_mode_d[i]        = wdat_q[5:4];
                                    wptr_d[i]           = 1'b0;
                                    rptr_d[i]           = 1'b0;
                                    status_pending_d[i] = 1'b0;
                                    cw_strobe_d[i]      = 1'b1;
                                end
                            end
                        end
                    end else begin
                        d_wr_d = wdat_q;
                        for (int i = 0; i < 3; i++) begin
                            if (waddr_q == 2'(i)) begin
                                wr_strobe_d[i] = 1'b1;
                                case (rw_mode_q[i])
                                    2'b10: wr_msb_d = 1'b1;
                                    2'b11: begin
                                        wr_msb_d  = wptr_q[i];
                                        wptr_d[i] = ~wptr_q[i];
                                    end
                                    default: wr_msb_d = 1'b0;
                                endcase
                            end
                        end
                    end
                end
            end

            RD_ACT: begin
                if (cs_s || (!rd_s && !wr_s)) begin
                    state_d = ABORT;
                end else if (rd_s) begin
                    // byte consumed: status reads clear the pending flag, LSB/MSB reads advance rptr
                    state_d = IDLE;
                    for (int i = 0; i < 3; i++) begin
                        if (rd_a_q == 2'(i)) begin
                            if (rd_status_q) begin
                                status_pending_d[i] = 1'b0;
                            end else if (rw_mode_q[i] == 2'b11) begin
                                rptr_d[i] = ~rptr_q[i];
                            end
                        end
                    end
                end else begin
                    d_oe_d = (rd_a_q != 2'd3);
                end
            end

            ABORT: begin
                if (rd_s && wr_s) state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            cs_sync_q        <= '1;
            rd_sync_q        <= '1;
            wr_sync_q        <= '1;
            state_q          <= IDLE;
            waddr_q          <= 2'd0;
            wdat_q           <= 8'd0;
            rd_a_q           <= 2'd0;
            rd_status_q      <= 1'b0;
            rw_mode_q        <= {3{2'b01}};
            wptr_q           <= 3'b000;
            rptr_q           <= 3'b000;
            status_pending_q <= 3'b000;
            d_out_q          <= 8'd0;
            d_oe_q           <= 1'b0;
            control_word_q   <= 8'd0;
            cw_strobe_q      <= 3'b000;
            wr_strobe_q      <= 3'b000;
            d_wr_q           <= 8'd0;
            wr_msb_q         <= 1'b0;
            latch_strobe_q   <= 3'b000;
        end else begin
            cs_sync_q        <= cs_sync_d;
            rd_sync_q        <= rd_sync_d;
            wr_sync_q        <= wr_sync_d;
            state_q          <= state_d;
            waddr_q          <= waddr_d;
            wdat_q           <= wdat_d;
            rd_a_q           <= rd_a_d;
            rd_status_q      <= rd_status_d;
            rw_mode_q        <= rw_mode_d;
            wptr_q           <= wptr_d;
            rptr_q           <= rptr_d;
            status_pending_q <= status_pending_d;
            d_out_q          <= d_out_d;
            d_oe_q           <= d_oe_d;
            control_word_q   <= control_word_d;
            cw_strobe_q      <= cw_strobe_d;
            wr_strobe_q      <= wr_strobe_d;
            d_wr_q           <= d_wr_d;
            wr_msb_q         <= wr_msb_d;
            latch_strobe_q   <= latch_strobe_d;
        end
    end

    assign D_out        = d_out_q;
    assign D_oe         = d_oe_q;
    assign control_word = control_word_q;
    assign cw_strobe    = cw_strobe_q;
    assign wr_strobe    = wr_strobe_q;
    assign D_wr         = d_wr_q;
    assign wr_msb       = wr_msb_q;
    assign latch_strobe = latch_strobe_q;

endmodule

// File: tb/tb_bus_sequencer.sv
// Bench for bus_sequencer: directed bus accesses, expected strobes/read bytes queued in a scoreboard.
// Two instances (SYNC_STAGES 2 and 3) share the bus; the first is fully scoreboarded, both are timed.
// A negedge monitor pops one expectation per strobe pulse and per D_oe rising edge.
module tb_bus_sequencer;

    logic        CLK, RESET, CS, RD, WR;
    logic [1:0]  A;
    logic [7:0]  D_in;
    logic [15:0] count0, count1, count2;
    logic [7:0]  status0, status1, status2;

    logic [7:0]  D_out, control_word, D_wr;
    logic        D_oe, wr_msb;
    logic [2:0]  cw_strobe, wr_strobe, latch_strobe;

    logic [7:0]  D_out_3, control_word_3, D_wr_3;
    logic        D_oe_3, wr_msb_3;
    logic [2:0]  cw_strobe_3, wr_strobe_3, latch_strobe_3;

    bus_sequencer #(.SYNC_STAGES(2)) dut2 (
        .CLK(CLK), .RESET(RESET), .CS(CS), .RD(RD), .WR(WR), .A(A), .D_in(D_in),
        .D_out(D_out), .D_oe(D_oe), .control_word(control_word), .cw_strobe(cw_strobe),
        .wr_strobe(wr_strobe), .D_wr(D_wr), .wr_msb(wr_msb), .latch_strobe(latch_strobe),
        .count0(count0), .count1(count1), .count2(count2),
        .status0(status0), .status1(status1), .status2(status2)
    );

    bus_sequencer #(.SYNC_STAGES(3)) dut3 (
        .CLK(CLK), .RESET(RESET), .CS(CS), .RD(RD), .WR(WR), .A(A), .D_in(D_in),
        .D_out(D_out_3), .D_oe(D_oe_3), .control_word(control_word_3), .cw_strobe(cw_strobe_3),
        .wr_strobe(wr_strobe_3), .D_wr(D_wr_3), .wr_msb(wr_msb_3), .latch_strobe(latch_strobe_3),
        .count0(count0), .count1(count1), .count2(count2),
        .status0(status0), .status1(status1), .status2(status2)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        bit         is_rd;
        logic [8:0] strb;   // {cw, wr, latch}
        logic [7:0] dat;
        logic       msb;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   l2, l3;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic push_strb(input logic [2:0] cw, input logic [2:0] wr, input logic [2:0] lt,
                             input logic [7:0] dat, input logic msb);
        exp_t e;
        e.is_rd = 1'b0; e.strb = {cw, wr, lt}; e.dat = dat; e.msb = msb;
        sb.push_back(e);
    endtask

    task automatic push_rd(input logic [7:0] dat);
        exp_t e;
        e.is_rd = 1'b1; e.strb = 9'd0; e.dat = dat; e.msb = 1'b0;
        sb.push_back(e);
    endtask

    // monitor: strobe pulses and read-data presentations of the SYNC_STAGES=2 instance
    initial begin
        logic oe_prev;
        exp_t e;
        oe_prev = 1'b0;
        forever begin
            @(negedge CLK);
            if (|{cw_strobe, wr_strobe, latch_strobe}) begin
                if (sb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_strobe: got cw=%b wr=%b lt=%b expected none",
                             cw_strobe, wr_strobe, latch_strobe);
                end else begin
                    e = sb.pop_front();
                    chk("event_kind_strobe", {31'd0, e.is_rd}, 32'd0);
                    chk("strobes", {23'd0, cw_strobe, wr_strobe, latch_strobe}, {23'd0, e.strb});
                    if (e.strb[8:6] != 3'b000) chk("control_word", {24'd0, control_word}, {24'd0, e.dat});
                    if (e.strb[5:3] != 3'b000) begin
                        chk("d_wr", {24'd0, D_wr}, {24'd0, e.dat});
                        chk("wr_msb", {31'd0, wr_msb}, {31'd0, e.msb});
                    end
                end
            end
            if (D_oe && !oe_prev) begin
                if (sb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_read: got D_out=0x%0h expected no read", D_out);
                end else begin
                    e = sb.pop_front();
                    chk("event_kind_read", {31'd0, e.is_rd}, 32'd1);
                    chk("d_out", {24'd0, D_out}, {24'd0, e.dat});
                end
            end
            oe_prev = D_oe;
        end
    end

    // write access; returns edges from first edge seeing WR high to the strobe (0 = none)
    task automatic bus_write(input logic [1:0] a, input logic [7:0] d, output int lat2, output int lat3);
        @(negedge CLK); A = a; D_in = d; CS = 1'b0;
        @(negedge CLK); WR = 1'b0;
        repeat (6) @(negedge CLK);
        WR = 1'b1; lat2 = 0; lat3 = 0;
        for (int e = 1; e <= 8; e++) begin
            @(posedge CLK); #1;
            if (lat2 == 0 && (|{cw_strobe, wr_strobe, latch_strobe})) lat2 = e;
            if (lat3 == 0 && (|{cw_strobe_3, wr_strobe_3, latch_strobe_3})) lat3 = e;
        end
        CS = 1'b1;
        repeat (6) @(negedge CLK);
    endtask

    // read access; returns edges from first edge seeing RD low to D_oe high (0 = never)
    task automatic bus_read(input logic [1:0] a, output int lat2, output int lat3);
        @(negedge CLK); A = a; CS = 1'b0;
        @(negedge CLK); RD = 1'b0; lat2 = 0; lat3 = 0;
        for (int e = 1; e <= 8; e++) begin
            @(posedge CLK); #1;
            if (lat2 == 0 && D_oe) lat2 = e;
            if (lat3 == 0 && D_oe_3) lat3 = e;
        end
        RD = 1'b1;
        repeat (6) @(negedge CLK);
        CS = 1'b1;
        repeat (6) @(negedge CLK);
    endtask

    initial begin
        RESET = 1'b1; CS = 1'b1; RD = 1'b1; WR = 1'b1; A = 2'd0; D_in = 8'd0;
        count0 = 16'h0000; count1 = 16'hABCD; count2 = 16'h00EF;
        status0 = 8'h00; status1 = 8'h36; status2 = 8'h00;
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        chk("rst_d_out", {24'd0, D_out}, 32'd0);
        chk("rst_d_oe", {31'd0, D_oe}, 32'd0);
        chk("rst_control_word", {24'd0, control_word}, 32'd0);
        chk("rst_d_wr", {24'd0, D_wr}, 32'd0);
        chk("rst_wr_msb", {31'd0, wr_msb}, 32'd0);
        chk("rst_strobes", {23'd0, cw_strobe, wr_strobe, latch_strobe}, 32'd0);

        // counter 0 to LSB/MSB mode, then two byte writes
        push_strb(3'b001, 3'b000, 3'b000, 8'h30, 1'b0);
        bus_write(2'd3, 8'h30, l2, l3);
        push_strb(3'b000, 3'b001, 3'b000, 8'h34, 1'b0);
        bus_write(2'd0, 8'h34, l2, l3);
        push_strb(3'b000, 3'b001, 3'b000, 8'h12, 1'b1);
        bus_write(2'd0, 8'h12, l2, l3);

        // counter 1 to LSB/MSB mode, three reads wrap LSB/MSB/LSB
        push_strb(3'b010, 3'b000, 3'b000, 8'h70, 1'b0);
        bus_write(2'd3, 8'h70, l2, l3);
        push_rd(8'hCD); bus_read(2'd1, l2, l3);
        push_rd(8'hAB); bus_read(2'd1, l2, l3);
        push_rd(8'hCD); bus_read(2'd1, l2, l3);

        // counter latch resets the read pointer
        push_strb(3'b000, 3'b000, 3'b010, 8'h00, 1'b0);
        bus_write(2'd3, 8'h40, l2, l3);

        // read-back count+status, then a status-only read-back that must be ignored
        push_strb(3'b000, 3'b000, 3'b010, 8'h00, 1'b0);
        bus_write(2'd3, 8'hC4, l2, l3);
        bus_write(2'd3, 8'hE4, l2, l3);
        push_rd(8'h36); bus_read(2'd1, l2, l3);
        push_rd(8'hCD); bus_read(2'd1, l2, l3);
        push_rd(8'hAB); bus_read(2'd1, l2, l3);

        // read of the control address never drives the bus
        bus_read(2'd3, l2, l3);
        chk("a3_read_no_oe", l2, 32'd0);

        // RD and WR low together: abort; releasing RD first keeps the write suppressed
        @(negedge CLK); A = 2'd0; D_in = 8'h99; CS = 1'b0;
        @(negedge CLK); RD = 1'b0; WR = 1'b0;
        repeat (8) @(negedge CLK);
        chk("abort_no_oe", {31'd0, D_oe}, 32'd0);
        RD = 1'b1;
        repeat (8) @(negedge CLK);
        WR = 1'b1;
        repeat (8) @(negedge CLK);
        CS = 1'b1;
        repeat (6) @(negedge CLK);
        push_strb(3'b000, 3'b001, 3'b000, 8'h55, 1'b0);
        bus_write(2'd0, 8'h55, l2, l3);

        // CS raised mid-write: no strobe and wptr must not advance
        @(negedge CLK); A = 2'd0; D_in = 8'h66; CS = 1'b0;
        @(negedge CLK); WR = 1'b0;
        repeat (8) @(negedge CLK);
        CS = 1'b1;
        repeat (8) @(negedge CLK);
        WR = 1'b1;
        repeat (8) @(negedge CLK);
        push_strb(3'b000, 3'b001, 3'b000, 8'h77, 1'b1);
        bus_write(2'd0, 8'h77, l2, l3);

        // reset in the middle of a read
        count0 = 16'h5678;
        push_rd(8'h78); bus_read(2'd0, l2, l3);
        push_rd(8'h56);
        @(negedge CLK); A = 2'd0; CS = 1'b0;
        @(negedge CLK); RD = 1'b0;
        l2 = 0;
        for (int e = 1; e <= 10 && l2 == 0; e++) begin
            @(posedge CLK); #1;
            if (D_oe) l2 = e;
        end
        chk("pre_reset_oe_seen", {31'd0, (l2 != 0)}, 32'd1);
        @(negedge CLK); RESET = 1'b1; RD = 1'b1; CS = 1'b1;
        @(posedge CLK); #1;
        chk("reset_in_read_d_oe", {31'd0, D_oe}, 32'd0);
        chk("reset_in_read_d_out", {24'd0, D_out}, 32'd0);
        @(negedge CLK); RESET = 1'b0;
        repeat (4) @(negedge CLK);
        // modes back to LSB-only after reset
        push_rd(8'h78); bus_read(2'd0, l2, l3);

        // latency for both synchronizer depths
        push_strb(3'b000, 3'b100, 3'b000, 8'h21, 1'b0);
        bus_write(2'd2, 8'h21, l2, l3);
        chk("wr_latency_sync2", l2, 32'd3);
        chk("wr_latency_sync3", l3, 32'd4);
        push_rd(8'hEF);
        bus_read(2'd2, l2, l3);
        chk("rd_latency_sync2", l2, 32'd3);
        chk("rd_latency_sync3", l3, 32'd4);

        repeat (4) @(negedge CLK);
        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
